// File: rtl/sdlx_exec_stage.sv
// sdlx_exec_stage: SDLX R-type execute stage with operand bypass and register-file writeback.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        instruction handshake, transfer when both high at posedge
//   in_func                  ALU function code
//   in_rd/in_rs1/in_rs2      destination and source register numbers
//   in_a/in_b                register-file read data for rs1/rs2
//   wb_we/wb_rd/wb_din       register-file write port, result visible one cycle after accept
//   busy                     iterative multiply in progress
//   err_illegal              one-cycle pulse after an accepted undefined function code
// Optional feature: define SDLX_MUL_EN to build in the iterative MUL (code 12) and its FSM.
module sdlx_exec_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_func,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_din,
    output logic        busy,
    output logic        err_illegal
);
    logic [31:0] a, b, res;
    logic        legal, accept;
    // Forward the result being written this cycle; r0 is never forwarded.
    assign a = (wb_we && in_rs1 != 5'd0 && in_rs1 == wb_rd) ? wb_din : in_a;
    assign b = (wb_we && in_rs2 != 5'd0 && in_rs2 == wb_rd) ? wb_din : in_b;
    assign accept = in_valid && in_ready;
    always_comb begin
        res = 32'd0;
        case (in_func)
            4'd0:    res = a + b;
            4'd1:    res = a - b;
            4'd2:    res = a & b;
            4'd3:    res = a | b;
            4'd4:    res = a ^ b;
            4'd5:    res = a << b[4:0];
            4'd6:    res = a >> b[4:0];
            4'd7:    res = $signed(a) >>> b[4:0];
            4'd8:    res = {31'd0, $signed(a) < $signed(b)};
            4'd9:    res = {31'd0, $signed(a) > $signed(b)};
            4'd10:   res = {31'd0, a == b};
            4'd11:   res = {31'd0, a != b};
            default: res = 32'd0;
        endcase
    end
`ifdef SDLX_MUL_EN
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] MUL  = 1'b1;
    logic [0:0]  state;
    logic [4:0]  cnt;
    logic [4:0]  mul_rd;
    logic [31:0] mcand, mplier, acc, partial;
    assign legal    = in_func <= 4'd12;
    assign in_ready = !rst && state == IDLE;
    assign busy     = state == MUL;
    assign partial  = mplier[0] ? mcand : 32'd0;
`else
    assign legal    = in_func <= 4'd11;
    assign in_ready = !rst;
    assign busy     = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_we       <= 1'b0;
            wb_rd       <= 5'd0;
            wb_din      <= 32'd0;
            err_illegal <= 1'b0;
`ifdef SDLX_MUL_EN
            state       <= IDLE;
            cnt         <= 5'd0;
`endif
        end else begin
            wb_we       <= 1'b0;
            err_illegal <= 1'b0;
            if (accept) begin
                if (!legal)
                    err_illegal <= 1'b1;
`ifdef SDLX_MUL_EN
                else if (in_func == 4'd12) begin
                    state  <= MUL;
                    cnt    <= 5'd0;
                    mcand  <= a;
                    mplier <= b;
                    acc    <= 32'd0;
                    mul_rd <= in_rd;
                end
`endif
                else if (in_rd != 5'd0) begin
                    wb_we  <= 1'b1;
                    wb_rd  <= in_rd;
                    wb_din <= res;
                end
            end
`ifdef SDLX_MUL_EN
            // One multiplier bit per cycle; the last partial sum goes straight to writeback.
            if (state == MUL) begin
                acc    <= acc + partial;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 5'd1;
                if (cnt == 5'd31) begin
                    state <= IDLE;
                    if (mul_rd != 5'd0) begin
                        wb_we  <= 1'b1;
                        wb_rd  <= mul_rd;
                        wb_din <= acc + partial;
                    end
                end
            end
`endif
        end
    end
endmodule

// File: doc/sdlx_exec_stage.md
SDLX_EXEC_STAGE -- requirements
Module: sdlx_exec_stage

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on posedge clk.
REQ-002 SHALL: rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-003 SHALL: in_valid  input  1  decoded R-type instruction present.
REQ-004 SHALL: in_ready  output  1  stage can accept; transfer occurs when in_valid & in_ready at posedge.
REQ-005 SHALL: in_func  input  4  ALU function code.
REQ-006 SHALL: in_rd, in_rs1, in_rs2  input  5 each  destination and source register numbers.
REQ-007 SHALL: in_a, in_b  input  32 each  register-file read data for rs1, rs2.
REQ-008 SHALL: wb_we, wb_rd, wb_din  output  1/5/32  drive register-file WE, RD, Din.
REQ-009 SHALL: busy  output  1  multi-cycle operation in progress.
REQ-010 SHALL: err_illegal  output  1  one-cycle pulse on an accepted undefined in_func.

Function
REQ-011 SHALL: in_func codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT signed, 9 SGT signed, 10 SEQ, 11 SNE, 12 MUL (macro-dependent); 13-15 illegal.
REQ-012 SHALL: ADD/SUB wrap modulo 2^32, no overflow flag; shifts use b[4:0] only; compares yield 32'd1 or 32'd0.
REQ-013 SHALL: single-cycle ops: result registered at the accepting edge; wb_we=1 for exactly the following cycle (latency 1).
REQ-014 SHALL: operand bypass: if wb_we=1 and in_rs1==wb_rd, use wb_din instead of in_a; same for in_rs2/in_b; both may bypass simultaneously.
REQ-015 SHALL: in_rd==0 -> wb_we forced 0 (r0 never written); bypass never matches r0.
REQ-016 SHALL: illegal in_func -> wb_we stays 0, err_illegal=1 for the following cycle, in_ready unaffected.
REQ-017 SHALL: FSM states IDLE, MUL; IDLE->MUL on accepted MUL; MUL->IDLE after 32 iteration cycles.
REQ-018 SHALL: MUL = iterative shift-add, one multiplier bit per cycle, 5-bit counter 0..31, result low 32 bits of product.
REQ-019 SHALL: in MUL, busy=1, in_ready=0; in_valid ignored; wb_we=1 for one cycle after the 32nd iteration edge (33 cycles after acceptance).
REQ-020 SHALL: in IDLE, in_ready=1; back-to-back single-cycle ops accepted every cycle.
REQ-021 SHALL: wb_rd and wb_din hold last values when wb_we=0.

Reset
REQ-022 SHALL: on rst: FSM=IDLE, counter=0, wb_we=0, wb_rd=0, wb_din=0, err_illegal=0, busy=0, in_ready=1 from the next cycle.
REQ-023 SHALL: rst during MUL aborts it with no writeback; rst overrides a simultaneous in_valid.

Configuration
REQ-024 SHALL: macro SDLX_MUL_EN defined -> MUL code 12, FSM, counter and multiplier datapath compiled in.
REQ-025 SHALL: SDLX_MUL_EN undefined -> code 12 illegal per REQ-016, busy tied 0, in_ready tied 1 outside reset.

Verification
REQ-026 SHALL: ADD rd=3 a=5 b=7 -> next cycle wb_we=1, wb_rd=3, wb_din=12; following cycle wb_we=0.
REQ-027 SHALL: ADD rd=4 a=1 b=2 then SUB rd=5 rs1=4 in_a=4(stale) b=1 back-to-back -> wb_din=3 then 2 (bypass).
REQ-028 SHALL: SRA a=0x80000000 b=0x00000024 -> wb_din=0xF8000000; SLT a=0xFFFFFFFF b=1 -> 1; ADD 0xFFFFFFFF+1 -> 0.
REQ-029 SHALL: ADD rd=0 a=9 b=9 -> wb_we stays 0; func=14 -> err_illegal pulse, no writeback.
REQ-030 SHALL: SDLX_MUL_EN: MUL rd=6 a=6 b=7 -> busy=1 and in_ready=0 for 32 cycles, wb_din=42 at cycle 33; second in_valid during busy not accepted.
REQ-031 SHALL: SDLX_MUL_EN: rst asserted at iteration 10 of MUL -> no wb_we, busy=0 and in_ready=1 after reset.
